sysid_checker: RTL and testbench

//  Avalon-MM read master that sits directly downstream of the system-ID slave.

---
 rtl/sysid_checker.sv | 187 ++++++++++++++++++
 tb/tb_sysid_checker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the system-ID and timestamp words and checks them
// against the build-time constants. Optional retry-on-mismatch: define SYSID_CHECKER_RETRY_EN.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'd1380908974,
  parameter logic [31:0] EXPECTED_TS  = 32'd1278499610,
  parameter int          READ_LATENCY = 0,
  parameter int          TIMEOUT      = 255,
  parameter int          MAX_RETRIES  = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic [31:0] av_readdata,
  input  logic        av_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
`ifdef SYSID_CHECKER_RETRY_EN
  ,
  output logic [3:0]  retry_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK, DONE
  } state_t;

  state_t      state, state_n;
  logic [15:0] to_cnt;
  logic [1:0]  lat_cnt;
  logic        armed;
  logic        start_ok;
  logic        capture_id, capture_ts;
  logic        to_hit;
  logic        retry;
  logic        id_match, ts_match;

  // A start seen on the first edge after reset release is dropped.
  assign start_ok = start & armed;
  assign id_match = (id_value == EXPECTED_ID);
  assign ts_match = (ts_value == EXPECTED_TS);

  assign busy       = (state != IDLE) && (state != DONE);
  assign av_read    = (state == RD_ID) || (state == RD_TS);
  assign av_address = (state == RD_TS);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_n    = state;
    capture_id = 1'b0;
    capture_ts = 1'b0;
    to_hit     = 1'b0;
    retry      = 1'b0;
    case (state)
      IDLE: if (start_ok) state_n = RD_ID;
      RD_ID: begin
        if (!av_waitrequest) begin
          if (READ_LATENCY == 0) begin
            capture_id = 1'b1;
            state_n    = RD_TS;
          end else begin
            state_n = LAT_ID;
          end
        end else if (to_cnt == 16'(TIMEOUT - 1)) begin
          to_hit  = 1'b1;
          state_n = DONE;
        end
      end
      LAT_ID: begin
        if (lat_cnt == 2'(READ_LATENCY - 1)) begin
          capture_id = 1'b1;
          state_n    = RD_TS;
        end
      end
      RD_TS: begin
        if (!av_waitrequest) begin
          if (READ_LATENCY == 0) begin
            capture_ts = 1'b1;
            state_n    = CHECK;
          end else begin
            state_n = LAT_TS;
          end
        end else if (to_cnt == 16'(TIMEOUT - 1)) begin
          to_hit  = 1'b1;
          state_n = DONE;
        end
      end
      LAT_TS: begin
        if (lat_cnt == 2'(READ_LATENCY - 1)) begin
          capture_ts = 1'b1;
          state_n    = CHECK;
        end
      end
      CHECK: begin
`ifdef SYSID_CHECKER_RETRY_EN
        if (!(id_match && ts_match) && (retry_cnt < 4'(MAX_RETRIES))) begin
          retry   = 1'b1;
          state_n = RD_ID;
        end else begin
          state_n = DONE;
        end
`else
        state_n = DONE;
`endif
      end
      DONE:    if (start_ok) state_n = RD_ID;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments with the asynchronous reset in the sensitivity list.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Stall and latency counters idle at zero, so each RD_x/LAT_x entry starts from a clean count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt  <= '0;
      lat_cnt <= '0;
    end else begin
      if (av_read && av_waitrequest) to_cnt <= to_cnt + 16'd1;
      else                           to_cnt <= '0;
      if ((state == LAT_ID) || (state == LAT_TS)) begin
        if (state_n == state) lat_cnt <= lat_cnt + 2'd1;
        else                  lat_cnt <= '0;
      end else begin
        lat_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed    <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
`ifdef SYSID_CHECKER_RETRY_EN
      retry_cnt <= '0;
`endif
    end else begin
      armed <= 1'b1;
      if (capture_id) id_value <= av_readdata;
      if (capture_ts) ts_value <= av_readdata;
      if (((state == IDLE) || (state == DONE)) && start_ok) begin
        done    <= 1'b0;
        pass    <= 1'b0;
        id_ok   <= 1'b0;
        ts_ok   <= 1'b0;
        timeout <= 1'b0;
`ifdef SYSID_CHECKER_RETRY_EN
        retry_cnt <= '0;
`endif
      end
      if (to_hit) begin
        done    <= 1'b1;
        timeout <= 1'b1;
        pass    <= 1'b0;
        id_ok   <= 1'b0;
        ts_ok   <= 1'b0;
      end
      if (state == CHECK) begin
        id_ok <= id_match;
        ts_ok <= ts_match;
        pass  <= id_match & ts_match;
        if (state_n == DONE) done <= 1'b1;
      end
`ifdef SYSID_CHECKER_RETRY_EN
      if (retry) retry_cnt <= retry_cnt + 4'd1;
`endif
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Self-checking bench for sysid_checker: three instances cover zero latency, a short
// timeout and READ_LATENCY=2; the retry sequence runs when SYSID_CHECKER_RETRY_EN is defined.
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd1380908974;
  localparam logic [31:0] EXP_TS = 32'd1278499610;
  localparam logic [31:0] STALE  = 32'hDEAD_BEEF;
`ifdef SYSID_CHECKER_RETRY_EN
  localparam int FAIL_CYC = 13;
  localparam int FAIL_RTY = 3;
`else
  localparam int FAIL_CYC = 4;
  localparam int FAIL_RTY = 0;
`endif

  int checks = 0;
  int errors = 0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Instance 0: READ_LATENCY=0, TIMEOUT=255
  logic        start0 = 1'b0, wait0 = 1'b0;
  logic        addr0, read0, busy0, done0, pass0, idok0, tsok0, to0;
  logic [31:0] rd0, idv0, tsv0;
  logic [31:0] id_word = EXP_ID, ts_word = EXP_TS;
  int          bad_n = 0, id_reads = 0;
  logic        rd_clr = 1'b0;
  logic [3:0]  rty0, rty1, rty2;

  // Instance 1: TIMEOUT=8, slave always stalls
  logic        start1 = 1'b0, wait1 = 1'b1;
  logic        addr1, read1, busy1, done1, pass1, idok1, tsok1, to1;
  logic [31:0] idv1, tsv1;

  // Instance 2: READ_LATENCY=2, stale data at accept
  logic        start2 = 1'b0, wait2 = 1'b0;
  logic        addr2, read2, busy2, done2, pass2, idok2, tsok2, to2;
  logic [31:0] rd2, idv2, tsv2;
  logic        p0 = 1'b0, p1 = 1'b0, a0 = 1'b0, a1 = 1'b0;

  assign rd0 = addr0 ? ts_word : ((id_reads < bad_n) ? 32'h0BAD_0BAD : id_word);
  always @(posedge clock) begin
    if (rd_clr)                           id_reads <= 0;
    else if (read0 && !addr0 && !wait0)   id_reads <= id_reads + 1;
  end

  always @(posedge clock) begin
    p0 <= read2 & ~wait2;
    a0 <= addr2;
    p1 <= p0;
    a1 <= a0;
  end
  assign rd2 = p1 ? (a1 ? EXP_TS : EXP_ID) : STALE;

  sysid_checker #(.READ_LATENCY(0), .TIMEOUT(255)) u_dut (
    .clock(clock), .reset(reset), .start(start0),
    .av_address(addr0), .av_read(read0), .av_readdata(rd0), .av_waitrequest(wait0),
    .busy(busy0), .done(done0), .pass(pass0), .id_ok(idok0), .ts_ok(tsok0),
    .timeout(to0), .id_value(idv0), .ts_value(tsv0)
`ifdef SYSID_CHECKER_RETRY_EN
    , .retry_cnt(rty0)
`endif
  );

  sysid_checker #(.READ_LATENCY(0), .TIMEOUT(8)) u_to (
    .clock(clock), .reset(reset), .start(start1),
    .av_address(addr1), .av_read(read1), .av_readdata(32'h1234_5678), .av_waitrequest(wait1),
    .busy(busy1), .done(done1), .pass(pass1), .id_ok(idok1), .ts_ok(tsok1),
    .timeout(to1), .id_value(idv1), .ts_value(tsv1)
`ifdef SYSID_CHECKER_RETRY_EN
    , .retry_cnt(rty1)
`endif
  );

  sysid_checker #(.READ_LATENCY(2), .TIMEOUT(255)) u_lat (
    .clock(clock), .reset(reset), .start(start2),
    .av_address(addr2), .av_read(read2), .av_readdata(rd2), .av_waitrequest(wait2),
    .busy(busy2), .done(done2), .pass(pass2), .id_ok(idok2), .ts_ok(tsok2),
    .timeout(to2), .id_value(idv2), .ts_value(tsv2)
`ifdef SYSID_CHECKER_RETRY_EN
    , .retry_cnt(rty2)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic dn(input int which);
    case (which)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  task automatic set_start(input int which, input logic v);
    case (which)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  // Pulses start for one cycle (cycle 0); returns at the negedge of cycle 1 with cyc = 1.
  task automatic kick(input int which, output int cyc);
    @(negedge clock);
    set_start(which, 1'b1);
    @(negedge clock);
    set_start(which, 1'b0);
    cyc = 1;
  endtask

  task automatic wait_done(input int which, inout int cyc);
    while (!dn(which) && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  typedef struct {
    logic [31:0] id_w;
    logic [31:0] ts_w;
    logic        e_pass;
    logic        e_id;
    logic        e_ts;
  } vec_t;

  vec_t vecs[5];
  int   cyc;
  logic stable;

  initial begin
    vecs[0] = '{EXP_ID,                 EXP_TS,           1'b1, 1'b1, 1'b1};
    vecs[1] = '{EXP_ID,                 32'd0,            1'b0, 1'b1, 1'b0};
    vecs[2] = '{EXP_ID ^ 32'h8000_0000, EXP_TS,           1'b0, 1'b0, 1'b1};
    vecs[3] = '{EXP_ID,                 EXP_TS ^ 32'd1,   1'b0, 1'b1, 1'b0};
    vecs[4] = '{32'd0,                  32'd0,            1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_busy",  {31'd0, busy0}, 32'd0);
    check("rst_done",  {31'd0, done0}, 32'd0);
    check("rst_read",  {31'd0, read0}, 32'd0);
    check("rst_flags", {27'd0, pass0, idok0, tsok0, to0, addr0}, 32'd0);
    check("rst_idv",   idv0, 32'd0);
    check("rst_tsv",   tsv0, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Table-driven result checks on the zero-latency instance
    for (int i = 0; i < 5; i++) begin
      id_word = vecs[i].id_w;
      ts_word = vecs[i].ts_w;
      kick(0, cyc);
      wait_done(0, cyc);
      check($sformatf("v%0d_cyc", i), 32'(cyc), vecs[i].e_pass ? 32'd4 : 32'(FAIL_CYC));
      check($sformatf("v%0d_pass", i), {31'd0, pass0}, {31'd0, vecs[i].e_pass});
      check($sformatf("v%0d_idok", i), {31'd0, idok0}, {31'd0, vecs[i].e_id});
      check($sformatf("v%0d_tsok", i), {31'd0, tsok0}, {31'd0, vecs[i].e_ts});
      check($sformatf("v%0d_idv", i), idv0, vecs[i].id_w);
      check($sformatf("v%0d_tsv", i), tsv0, vecs[i].ts_w);
      check($sformatf("v%0d_busy_to", i), {30'd0, busy0, to0}, 32'd0);
`ifdef SYSID_CHECKER_RETRY_EN
      check($sformatf("v%0d_rty", i), {28'd0, rty0}, vecs[i].e_pass ? 32'd0 : 32'(FAIL_RTY));
`endif
    end

    // Stall 10 cycles on the ID read
    id_word = EXP_ID;
    ts_word = EXP_TS;
    wait0   = 1'b1;
    kick(0, cyc);
    stable = 1'b1;
    repeat (10) begin
      if (!(read0 && !addr0 && busy0)) stable = 1'b0;
      @(negedge clock);
      cyc++;
    end
    wait0 = 1'b0;
    wait_done(0, cyc);
    check("stall_stable", {31'd0, stable}, 32'd1);
    check("stall_cyc",    32'(cyc), 32'd14);
    check("stall_pass",   {31'd0, pass0}, 32'd1);
    check("stall_to",     {31'd0, to0}, 32'd0);

    // Timeout with waitrequest stuck high, TIMEOUT=8
    kick(1, cyc);
    wait_done(1, cyc);
    check("to_cyc",   32'(cyc), 32'd9);
    check("to_flag",  {31'd0, to1}, 32'd1);
    check("to_pass",  {29'd0, pass1, idok1, tsok1}, 32'd0);
    check("to_busy",  {31'd0, busy1}, 32'd0);
    check("to_read",  {31'd0, read1}, 32'd0);

    // READ_LATENCY=2, stale data on the bus at accept
    kick(2, cyc);
    wait_done(2, cyc);
    check("lat_cyc",  32'(cyc), 32'd8);
    check("lat_pass", {31'd0, pass2}, 32'd1);
    check("lat_idv",  idv2, EXP_ID);
    check("lat_tsv",  tsv2, EXP_TS);

    // Reset during LAT_TS (cycle 5), start coincident with release is dropped
    kick(2, cyc);
    repeat (4) @(negedge clock);
    check("mid_busy", {30'd0, busy2, read2}, 32'd2);
    reset = 1'b1;
    #1;
    check("mid_rst_state", {26'd0, busy2, done2, pass2, idok2, tsok2, to2}, 32'd0);
    check("mid_rst_idv",   idv2, 32'd0);
    @(negedge clock);
    reset  = 1'b0;
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    check("rel_start_ign", {30'd0, busy2, done2}, 32'd0);
    @(negedge clock);
    kick(2, cyc);
    wait_done(2, cyc);
    check("post_rst_cyc",  32'(cyc), 32'd8);
    check("post_rst_pass", {31'd0, pass2}, 32'd1);

`ifdef SYSID_CHECKER_RETRY_EN
    // Bad ID on the first two reads, good on the third
    @(negedge clock);
    rd_clr = 1'b1;
    @(negedge clock);
    rd_clr  = 1'b0;
    bad_n   = 2;
    id_word = EXP_ID;
    ts_word = EXP_TS;
    kick(0, cyc);
    wait_done(0, cyc);
    check("rty_cyc",  32'(cyc), 32'd10);
    check("rty_pass", {31'd0, pass0}, 32'd1);
    check("rty_cnt",  {28'd0, rty0}, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
